// File: rtl/traffic_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic light controller:
//   - state_t      : controller phases (NIGHT only when TRAFFIC_NIGHT_MODE_EN)
//   - LAMP_*       : lamp codes in {R,Y,G} order
//   - next_phase   : normal-cycle successor of a phase
//   - phase_duration : seconds loaded into the countdown on entering a phase
// Optional feature macro: TRAFFIC_NIGHT_MODE_EN
// ----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED1  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED2  = 3'd5
`ifdef TRAFFIC_NIGHT_MODE_EN
        ,
        NIGHT     = 3'd6
`endif
    } state_t;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    function automatic state_t next_phase(input state_t s);
        state_t n;
        case (s)
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = ALL_RED1;
            ALL_RED1:  n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            EW_YELLOW: n = ALL_RED2;
            default:   n = NS_GREEN;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] phase_duration(input state_t s, input int green,
                                                  input int yellow, input int all_red);
        logic [7:0] d;
        case (s)
            NS_GREEN, EW_GREEN:   d = 8'(green);
            NS_YELLOW, EW_YELLOW: d = 8'(yellow);
            ALL_RED1, ALL_RED2:   d = 8'(all_red);
            default:              d = 8'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_sec_tick.sv
// ----------------------------------------------------------------------------
// sec_tick_module
// One-second prescaler: counts CLK cycles 0..CLK_FREQ-1 and wraps.
// Ports:
//   CLK      in  sole clock, rising edge
//   RSTn     in  asynchronous active-low reset
//   Sec_Tick out registered pulse, high exactly while count = CLK_FREQ-1
// ----------------------------------------------------------------------------
module sec_tick_module #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic CLK,
    input  logic RSTn,
    output logic Sec_Tick
);

    localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = (count == LAST) ? '0 : count + 1'b1;
    end

    // Tick is registered from the next count so it lines up with count = LAST
    // while still coming straight from a flop.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            count    <= '0;
            Sec_Tick <= 1'b0;
        end else begin
            count    <= count_next;
            Sec_Tick <= (count_next == LAST);
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// ----------------------------------------------------------------------------
// traffic_light_ctrl
// Two-way intersection controller with per-phase second countdown.
// Optional feature macro: TRAFFIC_NIGHT_MODE_EN (adds Night_Sig synchronizer
// and a flashing-yellow NIGHT state).
// Ports:
//   CLK          in   sole clock, rising edge
//   RSTn         in   asynchronous active-low reset
//   Night_Sig    in   asynchronous night request (unused without the macro)
//   Number_Data  out  [7:0] seconds remaining in current phase (0 in NIGHT)
//   NS_Light     out  [2:0] north-south lamps {R,Y,G}
//   EW_Light     out  [2:0] east-west lamps {R,Y,G}
//   Sec_Tick     out  one-cycle pulse per second
// All outputs come directly from flops.
// ----------------------------------------------------------------------------
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int GREEN_TIME   = 30,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Night_Sig,
    output logic [7:0] Number_Data,
    output logic [2:0] NS_Light,
    output logic [2:0] EW_Light,
    output logic       Sec_Tick
);

    state_t     state, state_next;
    logic [7:0] num_next;
    logic [2:0] ns_next, ew_next;

    sec_tick_module #(.CLK_FREQ(CLK_FREQ)) u_sec_tick (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .Sec_Tick (Sec_Tick)
    );

`ifdef TRAFFIC_NIGHT_MODE_EN
    logic night_meta, night_sync;
    logic blink, blink_next;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            night_meta <= 1'b0;
            night_sync <= 1'b0;
            blink      <= 1'b0;
        end else begin
            night_meta <= Night_Sig;
            night_sync <= night_meta;
            blink      <= blink_next;
        end
    end
`else
    logic night_unused;
    assign night_unused = Night_Sig;
`endif

    always_comb begin
        state_next = state;
        num_next   = Number_Data;
`ifdef TRAFFIC_NIGHT_MODE_EN
        blink_next = blink;
`endif
        if (Sec_Tick) begin
`ifdef TRAFFIC_NIGHT_MODE_EN
            // Night request overrides the countdown from any phase.
            if (state == NIGHT) begin
                if (night_sync) begin
                    blink_next = ~blink;
                end else begin
                    state_next = ALL_RED2;
                    num_next   = phase_duration(ALL_RED2, GREEN_TIME, YELLOW_TIME, ALL_RED_TIME);
                end
            end else if (night_sync) begin
                state_next = NIGHT;
                num_next   = 8'd0;
                blink_next = 1'b1;
            end else
`endif
            if (Number_Data > 8'd1) begin
                num_next = Number_Data - 8'd1;
            end else begin
                state_next = next_phase(state);
                num_next   = phase_duration(state_next, GREEN_TIME, YELLOW_TIME, ALL_RED_TIME);
            end
        end

        // Lamps decode the next state so they change on the same edge as it.
        case (state_next)
            NS_GREEN:  begin ns_next = LAMP_G; ew_next = LAMP_R; end
            NS_YELLOW: begin ns_next = LAMP_Y; ew_next = LAMP_R; end
            EW_GREEN:  begin ns_next = LAMP_R; ew_next = LAMP_G; end
            EW_YELLOW: begin ns_next = LAMP_R; ew_next = LAMP_Y; end
`ifdef TRAFFIC_NIGHT_MODE_EN
            NIGHT: begin
                ns_next = blink_next ? LAMP_Y : LAMP_OFF;
                ew_next = blink_next ? LAMP_Y : LAMP_OFF;
            end
`endif
            default:   begin ns_next = LAMP_R; ew_next = LAMP_R; end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= NS_GREEN;
            Number_Data <= 8'(GREEN_TIME);
            NS_Light    <= LAMP_G;
            EW_Light    <= LAMP_R;
        end else begin
            state       <= state_next;
            Number_Data <= num_next;
            NS_Light    <= ns_next;
            EW_Light    <= ew_next;
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// ----------------------------------------------------------------------------
// tb_traffic_light_ctrl
// Self-checking bench for traffic_light_ctrl with CLK_FREQ=10, GREEN_TIME=5,
// YELLOW_TIME=2, ALL_RED_TIME=1. Night-mode scenario only with
// TRAFFIC_NIGHT_MODE_EN.
// ----------------------------------------------------------------------------
module tb_traffic_light_ctrl;

    localparam int CF = 10;
    localparam int GT = 5;
    localparam int YT = 2;
    localparam int RT = 1;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       Night_Sig = 1'b0;
    logic [7:0] Number_Data;
    logic [2:0] NS_Light;
    logic [2:0] EW_Light;
    logic       Sec_Tick;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] num;
        logic [2:0] ns;
        logic [2:0] ew;
    } exp_t;

    exp_t sb[$];

    traffic_light_ctrl #(
        .CLK_FREQ     (CF),
        .GREEN_TIME   (GT),
        .YELLOW_TIME  (YT),
        .ALL_RED_TIME (RT)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Night_Sig   (Night_Sig),
        .Number_Data (Number_Data),
        .NS_Light    (NS_Light),
        .EW_Light    (EW_Light),
        .Sec_Tick    (Sec_Tick)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reset held over two falling edges, released on a falling edge.
    task automatic do_reset();
        @(negedge CLK);
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
    endtask

    // Bounded wait for a tick seen at a falling edge.
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * CF; i++) begin
            @(negedge CLK);
            if (Sec_Tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_exp(input logic [7:0] num, input logic [2:0] ns, input logic [2:0] ew);
        exp_t e;
        e.num = num;
        e.ns  = ns;
        e.ew  = ew;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        bit pre_ok;
        @(negedge CLK);
        RSTn = 1'b0;
        #1;
        checks++;
        if ({Number_Data, NS_Light, EW_Light, Sec_Tick} !== {8'd5, 3'b001, 3'b100, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got num=%0d ns=%b ew=%b tick=%b, want num=5 ns=001 ew=100 tick=0",
                     Number_Data, NS_Light, EW_Light, Sec_Tick);
        end
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        pre_ok = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            if (k < 9 && Sec_Tick !== 1'b0) pre_ok = 1'b0;
        end
        checks++;
        if (!pre_ok) begin
            errors++;
            $display("FAIL early_tick: got tick before edge 9, want first tick at edge 9");
        end
        checks++;
        if (Sec_Tick !== 1'b1) begin
            errors++;
            $display("FAIL first_tick: got tick=%b after edge 9, want 1", Sec_Tick);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (Number_Data !== 8'd4) begin
            errors++;
            $display("FAIL first_decrement: got num=%0d, want 4", Number_Data);
        end
    endtask

    task automatic test_free_run();
        int         ph[17] = '{0,0,0,0,0,1,1,2,3,3,3,3,3,4,4,5,0};
        logic [7:0] nums[17] = '{5,4,3,2,1,2,1,1,5,4,3,2,1,2,1,1,5};
        logic [2:0] ns_t[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
        logic [2:0] ew_t[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_t e;
        bit ok;
        do_reset();
        for (int i = 0; i < 17; i++) push_exp(nums[i], ns_t[ph[i]], ew_t[ph[i]]);
        #1;
        e = sb.pop_front();
        checks++;
        if ({Number_Data, NS_Light, EW_Light} !== {e.num, e.ns, e.ew}) begin
            errors++;
            $display("FAIL free_run_start: got num=%0d ns=%b ew=%b, want num=%0d ns=%b ew=%b",
                     Number_Data, NS_Light, EW_Light, e.num, e.ns, e.ew);
        end
        for (int t = 1; t <= 16; t++) begin
            wait_tick(ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL free_run_tick_timeout: step %0d got no tick, want one within %0d cycles", t, 2 * CF);
                sb.delete();
                return;
            end
            @(posedge CLK);
            #1;
            e = sb.pop_front();
            checks++;
            if ({Number_Data, NS_Light, EW_Light} !== {e.num, e.ns, e.ew}) begin
                errors++;
                $display("FAIL free_run_step%0d: got num=%0d ns=%b ew=%b, want num=%0d ns=%b ew=%b",
                         t, Number_Data, NS_Light, EW_Light, e.num, e.ns, e.ew);
            end
        end
    endtask

    task automatic test_exclusion();
        int ticks = 0;
        int last = -1;
        int first = -1;
        bit gap_ok = 1'b1;
        do_reset();
        for (int c = 1; c <= 200; c++) begin
            @(negedge CLK);
            checks++;
            if (NS_Light[1:0] != 2'b00 && EW_Light[1:0] != 2'b00) begin
                errors++;
                $display("FAIL exclusion_cycle%0d: got ns=%b ew=%b, want no G/Y on both", c, NS_Light, EW_Light);
            end
            if (Sec_Tick === 1'b1) begin
                if (last >= 0 && c - last != CF) gap_ok = 1'b0;
                if (first < 0) first = c;
                last = c;
                ticks++;
            end
        end
        checks++;
        if (ticks != 20) begin
            errors++;
            $display("FAIL tick_count: got %0d ticks in 200 cycles, want 20", ticks);
        end
        checks++;
        if (!gap_ok || first != 9) begin
            errors++;
            $display("FAIL tick_spacing: got first=%0d spacing_ok=%0d, want first=9 spacing 10", first, gap_ok);
        end
    endtask

    task automatic test_reset_mid_phase();
        bit ok;
        bit found = 1'b0;
        bit pre_ok = 1'b1;
        do_reset();
        for (int i = 0; i < 12 && !found; i++) begin
            wait_tick(ok);
            if (!ok) break;
            @(posedge CLK);
            #1;
            if (Number_Data === 8'd3 && EW_Light === 3'b001) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_ew_green_3: got num=%0d ew=%b, want num=3 ew=001", Number_Data, EW_Light);
            return;
        end
        #2;
        RSTn = 1'b0;
        #1;
        checks++;
        if ({Number_Data, NS_Light, EW_Light, Sec_Tick} !== {8'd5, 3'b001, 3'b100, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got num=%0d ns=%b ew=%b tick=%b, want num=5 ns=001 ew=100 tick=0",
                     Number_Data, NS_Light, EW_Light, Sec_Tick);
        end
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({Number_Data, NS_Light, EW_Light, Sec_Tick} !== {8'd5, 3'b001, 3'b100, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got num=%0d ns=%b ew=%b tick=%b, want num=5 ns=001 ew=100 tick=0",
                     Number_Data, NS_Light, EW_Light, Sec_Tick);
        end
        @(negedge CLK);
        RSTn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            if (k < 9 && Sec_Tick !== 1'b0) pre_ok = 1'b0;
        end
        checks++;
        if (!pre_ok || Sec_Tick !== 1'b1) begin
            errors++;
            $display("FAIL tick_after_mid_reset: got tick=%b early_ok=%0d, want tick first at edge 9", Sec_Tick, pre_ok);
        end
    endtask

`ifdef TRAFFIC_NIGHT_MODE_EN
    task automatic test_night();
        exp_t e;
        bit ok;
        do_reset();
        @(negedge CLK);
        Night_Sig = 1'b1;
        push_exp(8'd0, 3'b010, 3'b010);
        push_exp(8'd0, 3'b000, 3'b000);
        push_exp(8'd0, 3'b010, 3'b010);
        push_exp(8'd1, 3'b100, 3'b100);
        push_exp(8'd5, 3'b001, 3'b100);
        for (int t = 1; t <= 5; t++) begin
            wait_tick(ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL night_tick_timeout: step %0d got no tick", t);
                sb.delete();
                return;
            end
            @(posedge CLK);
            #1;
            e = sb.pop_front();
            checks++;
            if ({Number_Data, NS_Light, EW_Light} !== {e.num, e.ns, e.ew}) begin
                errors++;
                $display("FAIL night_step%0d: got num=%0d ns=%b ew=%b, want num=%0d ns=%b ew=%b",
                         t, Number_Data, NS_Light, EW_Light, e.num, e.ns, e.ew);
            end
            if (t == 3) Night_Sig = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_exclusion();
        test_reset_mid_phase();
`ifdef TRAFFIC_NIGHT_MODE_EN
        test_night();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
